id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID→EX pipeline stage for the RISC-V core: carries decoded operands, immediate, PC, destination register and ALU/jump/branch opcodes from decode to execute. Adds a valid/ready handshake with a two-entry skid buffer, so back-pressure from EX never forms a combinational path into ID. Also adds a flush input for branch/jump redirect and NOP-bubble insertion whenever the stage holds no valid instruction.

## Interface
- XLEN, 32, width of operands, immediate and PC
- REG_ADDR_W, 5, destination register index width
- ALU_W, 5, ALU opcode width; value 0 is ALU NOP
- JUMP_W, 2, jump opcode width; value 0 is no-jump
- BRANCH_W, 3, branch opcode width; value 0 is no-branch

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at posedge resets)
- flush  in  1  discard all held and incoming instructions this cycle
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_pc, id_reg1, id_reg2, id_imm  in  XLEN each  decoded payload
- id_rd  in  REG_ADDR_W  destination register
- id_rd_enable  in  1  writeback enable
- id_alu_op / id_jump_op / id_branch_op  in  ALU_W / JUMP_W / BRANCH_W  opcodes
- ex_valid  out  1  EX-side instruction valid
- ex_ready  in  1  EX consumes the instruction this cycle
- ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_rd_enable, ex_alu_op, ex_jump_op, ex_branch_op  out  same widths as id_ counterparts

## Operation
- Storage: main register (drives ex_*) and skid register, each with a valid bit.
- States: EMPTY (neither valid), FULL (main only), SKID (both).
- accept = id_valid & id_ready; pop = ex_valid & ex_ready.
- id_ready = rst & (state != SKID). It depends only on registered state and rst, never on ex_ready.
- ex_valid = main valid.
- EMPTY: accept → FULL, main ← id.
- FULL:
  - accept & pop → FULL, main ← id.
  - accept & !pop → SKID, skid ← id.
  - !accept & pop → EMPTY.
  - Otherwise hold.
- SKID: no accept. pop → FULL, main ← skid. Otherwise hold.
- Bubble gating: while ex_valid=0, ex_rd_enable, ex_alu_op, ex_jump_op and ex_branch_op read 0 (gated combinationally by main valid). ex_pc/reg1/reg2/imm/rd hold their last value (don't-care).
- flush=1 at posedge:
  - Next state EMPTY; both valid bits cleared.
  - Any id instruction offered that cycle is dropped, even if id_ready=1.
  - Payload registers are not required to clear.
- Priority: reset > flush > normal transitions.
- Payload is captured unmodified; no width conversion or arithmetic.

## Timing
- Reset:
  - State EMPTY; all ex_* outputs 0; ex_valid 0.
  - id_ready is 0 while rst is low and 1 on the first cycle after rst returns high.
  - Reset asserted mid-operation discards both entries on that edge.
- Latency: instruction accepted at edge N appears on ex_* with ex_valid=1 after edge N.
- Throughput: 1 instruction/cycle sustained while ex_ready=1.
- ex_ready deasserting drops id_ready one cycle later. The instruction accepted in that cycle lands in the skid register and is not lost.
- Stalled EX: ex_* stable, with ex_valid held high, until pop.
- Flush with ex_ready=1 in the same cycle: the main entry counts as consumed by EX. The flush still empties the stage.
- Ordering: strictly FIFO. The skid entry is always presented before any later id instruction.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_valid=1, id_reg1=0xDEADBEEF → ex_valid=0, all ex_*=0, id_ready=0. After release, id_ready=1 on the first cycle.
- Streaming: 8 back-to-back instructions, id_pc=0x00,0x04,…,0x1C, ex_ready=1 → each appears exactly 1 cycle after accept, in order, with no bubbles.
- Back-pressure:
  - Drop ex_ready at pc=0x08 while ID keeps sending → pc=0x0C is captured in skid, then id_ready=0.
  - Restore ex_ready after 3 cycles → output sequence 0x08, 0x0C, 0x10 with no loss or duplication.
- Bubble gating: id_valid=0 for one cycle with id_alu_op=5, id_rd_enable=1 → ex_valid=0, ex_alu_op=0, ex_rd_enable=0, ex_jump_op=0, ex_branch_op=0.
- Flush in SKID:
  - With main=0x20 and skid=0x24, assert flush together with id_valid for pc=0x28 → next cycle ex_valid=0 and id_ready=1.
  - 0x24 and 0x28 never appear on ex_pc.
- Reset vs flush: rst=0 and flush=1 in the same cycle during streaming → reset result: all ex_* = 0, and id_ready=0 during reset.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with a two-entry skid buffer, flush and
// NOP-bubble gating; id_ready never depends on ex_ready.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_W      = 5,
  parameter int JUMP_W     = 2,
  parameter int BRANCH_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_reg1,
  input  logic [XLEN-1:0]       id_reg2,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_enable,
  input  logic [ALU_W-1:0]      id_alu_op,
  input  logic [JUMP_W-1:0]     id_jump_op,
  input  logic [BRANCH_W-1:0]   id_branch_op,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_reg1,
  output logic [XLEN-1:0]       ex_reg2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_rd_enable,
  output logic [ALU_W-1:0]      ex_alu_op,
  output logic [JUMP_W-1:0]     ex_jump_op,
  output logic [BRANCH_W-1:0]   ex_branch_op
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       reg1;
    logic [XLEN-1:0]       reg2;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_enable;
    logic [ALU_W-1:0]      alu_op;
    logic [JUMP_W-1:0]     jump_op;
    logic [BRANCH_W-1:0]   branch_op;
  } id_ex_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  id_ex_t in_d;
  id_ex_t main_q;
  id_ex_t skid_q;

  logic accept;
  logic pop;
  logic load_main;
  logic from_skid;
  logic load_skid;

  assign in_d = '{
    pc:        id_pc,
    reg1:      id_reg1,
    reg2:      id_reg2,
    imm:       id_imm,
    rd:        id_rd,
    rd_enable: id_rd_enable,
    alu_op:    id_alu_op,
    jump_op:   id_jump_op,
    branch_op: id_branch_op
  };

  assign id_ready = rst & (state != SKID);
  assign ex_valid = (state != EMPTY);
  assign accept   = id_valid & id_ready;
  assign pop      = ex_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    from_skid = 1'b0;
    load_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = SKID;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          state_nxt = FULL;
          load_main = 1'b1;
          from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Redirect drops everything, including this cycle's offer
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      from_skid = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= from_skid ? skid_q : in_d;
      if (load_skid) skid_q <= in_d;
    end
  end

  assign ex_pc        = main_q.pc;
  assign ex_reg1      = main_q.reg1;
  assign ex_reg2      = main_q.reg2;
  assign ex_imm       = main_q.imm;
  assign ex_rd        = main_q.rd;
  assign ex_rd_enable = main_q.rd_enable & ex_valid;
  assign ex_alu_op    = main_q.alu_op & {ALU_W{ex_valid}};
  assign ex_jump_op   = main_q.jump_op & {JUMP_W{ex_valid}};
  assign ex_branch_op = main_q.branch_op & {BRANCH_W{ex_valid}};

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a queue of accepted instructions
// models main/skid occupancy and the order EX must see them in.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_en;
    logic [4:0]  alu;
    logic [1:0]  jmp;
    logic [2:0]  br;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_reg1, id_reg2, id_imm;
  logic [4:0]  id_rd;
  logic        id_rd_enable;
  logic [4:0]  id_alu_op;
  logic [1:0]  id_jump_op;
  logic [2:0]  id_branch_op;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_reg1, ex_reg2, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_enable;
  logic [4:0]  ex_alu_op;
  logic [1:0]  ex_jump_op;
  logic [2:0]  ex_branch_op;

  int   vectors = 0;
  int   errors  = 0;
  pl_t  q[$];
  pl_t  cur;
  logic zero_pl = 1'b1;
  logic last_acc;
  logic leak_watch = 1'b0;
  logic leak = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_imm(id_imm), .id_rd(id_rd), .id_rd_enable(id_rd_enable),
    .id_alu_op(id_alu_op), .id_jump_op(id_jump_op),
    .id_branch_op(id_branch_op),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_enable(ex_rd_enable),
    .ex_alu_op(ex_alu_op), .ex_jump_op(ex_jump_op),
    .ex_branch_op(ex_branch_op)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pl_t mk(logic [31:0] pc);
    pl_t p;
    p.pc    = pc;
    p.reg1  = pc ^ 32'hA5A5_0000;
    p.reg2  = ~pc;
    p.imm   = pc * 3 + 1;
    p.rd    = pc[6:2] | 5'd1;
    p.rd_en = pc[2] | pc[3] | 1'b1;
    p.alu   = 5'((pc >> 2) % 31 + 1);
    p.jmp   = pc[3:2];
    p.br    = pc[4:2];
    return p;
  endfunction

  task automatic put();
    id_pc        = cur.pc;
    id_reg1      = cur.reg1;
    id_reg2      = cur.reg2;
    id_imm       = cur.imm;
    id_rd        = cur.rd;
    id_rd_enable = cur.rd_en;
    id_alu_op    = cur.alu;
    id_jump_op   = cur.jmp;
    id_branch_op = cur.br;
  endtask

  task automatic drive(logic v, logic [31:0] pc);
    cur = mk(pc);
    id_valid = v;
    put();
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge
  task automatic step();
    logic acc;
    logic pp;
    @(negedge clk);
    check("id_ready", 64'(rst && q.size() < 2), 64'(id_ready) ^ 64'(0) );
    check("ex_valid", 64'(ex_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("ex_pc",   64'(ex_pc),        64'(q[0].pc));
      check("ex_reg1", 64'(ex_reg1),      64'(q[0].reg1));
      check("ex_reg2", 64'(ex_reg2),      64'(q[0].reg2));
      check("ex_imm",  64'(ex_imm),       64'(q[0].imm));
      check("ex_rd",   64'(ex_rd),        64'(q[0].rd));
      check("ex_rden", 64'(ex_rd_enable), 64'(q[0].rd_en));
      check("ex_alu",  64'(ex_alu_op),    64'(q[0].alu));
      check("ex_jmp",  64'(ex_jump_op),   64'(q[0].jmp));
      check("ex_br",   64'(ex_branch_op), 64'(q[0].br));
    end else begin
      check("bub_rden", 64'(ex_rd_enable), 64'(0));
      check("bub_alu",  64'(ex_alu_op),    64'(0));
      check("bub_jmp",  64'(ex_jump_op),   64'(0));
      check("bub_br",   64'(ex_branch_op), 64'(0));
      if (zero_pl) begin
        check("rst_pc",   64'(ex_pc),   64'(0));
        check("rst_reg1", 64'(ex_reg1), 64'(0));
        check("rst_reg2", 64'(ex_reg2), 64'(0));
        check("rst_imm",  64'(ex_imm),  64'(0));
        check("rst_rd",   64'(ex_rd),   64'(0));
      end
    end
    if (leak_watch && ex_valid &&
        (ex_pc == 32'h24 || ex_pc == 32'h28))
      leak = 1'b1;
    acc = rst && id_valid && (q.size() < 2);
    pp  = (q.size() != 0) && ex_ready;
    @(posedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      q.delete();
      zero_pl = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        zero_pl  = 1'b0;
        last_acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    ex_ready = 1'b1;
    for (int i = 0; i < 4 && q.size() != 0; i++) step();
    check("drained", 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    drive(1'b1, 32'h40);
    cur.reg1 = 32'hDEAD_BEEF;
    put();
    @(posedge clk);
    #1;
    step();
    step();

    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4));
      step();
      check("stream_acc", 64'(last_acc), 64'(1));
    end
    drain();

    // EX stalls for 3 cycles starting when 0x08 sits in main
    pc = 32'h0;
    for (int c = 0; c < 12; c++) begin
      ex_ready = !(c >= 3 && c < 6);
      drive(1'b1, pc);
      step();
      if (last_acc) pc += 4;
    end
    drain();

    drive(1'b0, 32'h50);
    cur.alu = 5'd5;
    cur.rd_en = 1'b1;
    put();
    step();

    // Flush while both entries are held
    ex_ready = 1'b0;
    drive(1'b1, 32'h20);
    step();
    drive(1'b1, 32'h24);
    step();
    check("skid_full", 64'(q.size()), 64'(2));
    drive(1'b1, 32'h28);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    leak_watch = 1'b1;
    repeat (3) step();
    check("flush_leak", 64'(leak), 64'(0));
    leak_watch = 1'b0;

    // Reset and flush together mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4));
      step();
    end
    rst = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h110);
    step();
    flush = 1'b0;
    step();
    rst = 1'b1;
    drive(1'b1, 32'h114);
    step();
    check("post_rst_acc", 64'(last_acc), 64'(1));
    drain();

    pc = 32'h200;
    for (int c = 0; c < 80; c++) begin
      ex_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, pc);
      step();
      if (last_acc) pc += 4;
    end
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
